// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the bus_dma phi2 bus copy engine.
package bus_dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } dma_state_e;

  localparam logic [1:0] PH_DRIVE  = 2'd1;
  localparam logic [1:0] PH_RISE   = 2'd2;
  localparam logic [1:0] PH_SAMPLE = 2'd3;

  localparam logic BUS_IDLE_RW = 1'b1;
  localparam logic BUS_IDLE_EN = 1'b0;

endpackage

// File: rtl/bus_phase_gen.sv
// Free-running 4-clock bus phase counter with registered phi2 and per-phase strobes.
module bus_phase_gen
  import bus_dma_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] phase_o,
  output logic       phi2_o,
  output logic       drive_stb_o,
  output logic       sample_stb_o,
  output logic       commit_stb_o
);

  logic [1:0] phase_q, phase_d;
  logic       phi2_q, phi2_d;

  always_comb begin
    phase_d = phase_q + 2'd1;
    phi2_d  = (phase_d >= PH_RISE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      phi2_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      phi2_q  <= phi2_d;
    end
  end

  assign phase_o      = phase_q;
  assign phi2_o       = phi2_q;
  // Strobes mark the clock whose rising edge performs the action.
  assign drive_stb_o  = (phase_q == PH_DRIVE - 2'd1);
  assign sample_stb_o = (phase_q == PH_SAMPLE);
  assign commit_stb_o = (phase_q == PH_SAMPLE);

endmodule

// File: rtl/bus_dma.sv
// Single-command phi2 bus copy engine (read source byte, write destination byte).
// Optional fill mode is built when BUS_DMA_FILL_EN is defined.
module bus_dma
  import bus_dma_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_cmd_src,
  input  logic [15:0] i_cmd_dst,
  input  logic [15:0] i_cmd_len,
  input  logic        i_cmd_fill,
  input  logic [7:0]  i_cmd_fill_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_phi2,
  output logic [15:0] o_addr,
  output logic        o_rw,
  output logic        o_en,
  output logic [7:0]  o_wdata,
  input  logic [7:0]  i_rdata
);

  dma_state_e  state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, idx_q, idx_d;
  logic        fill_q, fill_d;
  logic [7:0]  data_q, data_d;
  logic        started_q, started_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d, en_q, en_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [1:0]  phase;
  logic        drive_stb, sample_stb, commit_stb;
  logic        fill_cmd;
  logic [7:0]  fill_byte;

`ifdef BUS_DMA_FILL_EN
  assign fill_cmd  = i_cmd_fill;
  assign fill_byte = i_cmd_fill_data;
`else
  logic unused_fill;
  assign unused_fill = ^{i_cmd_fill, i_cmd_fill_data};
  assign fill_cmd    = 1'b0;
  assign fill_byte   = 8'h00;
`endif

  logic unused_phase;
  assign unused_phase = ^phase;

  bus_phase_gen u_phase (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .phase_o      (phase),
    .phi2_o       (o_phi2),
    .drive_stb_o  (drive_stb),
    .sample_stb_o (sample_stb),
    .commit_stb_o (commit_stb)
  );

  assign o_cmd_ready = (state_q == StIdle) && !i_rst;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    data_d    = data_q;
    started_d = started_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    en_d      = en_q;
    wdata_d   = wdata_q;

    case (state_q)
      StIdle: begin
        if (i_cmd_valid && o_cmd_ready) begin
          src_d  = i_cmd_src;
          dst_d  = i_cmd_dst;
          len_d  = i_cmd_len;
          idx_d  = '0;
          fill_d = fill_cmd;
          if (fill_cmd) data_d = fill_byte;
          if (i_cmd_len == 16'd0) state_d = StDone;
          else if (fill_cmd)      state_d = StWr;
          else                    state_d = StRd;
        end
      end
      StRd: begin
        // started_q guards against a command accepted mid bus cycle.
        if (started_q && sample_stb) begin
          data_d    = i_rdata;
          started_d = 1'b0;
          state_d   = StWr;
        end
      end
      StWr: begin
        if (started_q && commit_stb) begin
          idx_d     = idx_q + 16'd1;
          started_d = 1'b0;
          if (idx_q + 16'd1 == len_q) state_d = StDone;
          else if (fill_q)            state_d = StWr;
          else                        state_d = StRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Bus outputs only change entering phase 1: hold after phi2 fall, setup before rise.
    if (drive_stb) begin
      if (state_q == StRd) begin
        addr_d    = src_q + idx_q;
        rw_d      = 1'b1;
        en_d      = 1'b1;
        started_d = 1'b1;
      end else if (state_q == StWr) begin
        addr_d    = dst_q + idx_q;
        rw_d      = 1'b0;
        en_d      = 1'b1;
        wdata_d   = data_q;
        started_d = 1'b1;
      end else begin
        rw_d = BUS_IDLE_RW;
        en_d = BUS_IDLE_EN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      fill_q    <= 1'b0;
      data_q    <= '0;
      started_q <= 1'b0;
      addr_q    <= '0;
      rw_q      <= BUS_IDLE_RW;
      en_q      <= BUS_IDLE_EN;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      data_q    <= data_d;
      started_q <= started_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      en_q      <= en_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_busy  = (state_q != StIdle);
  assign o_done  = (state_q == StDone);
  assign o_addr  = addr_q;
  assign o_rw    = rw_q;
  assign o_en    = en_q;
  assign o_wdata = wdata_q;

endmodule
